// File: rtl/ysyx_24080006_pma_pkg.sv
// rtl/ysyx_24080006_pma_pkg.sv - shared PMA types, default region table and lookup helper
//
// Purpose: access/fault enums, the region record, the default region table and
//          pma_lookup(), which returns the lowest-indexed region that fully
//          contains [addr, end].
// Config : YSYX_24080006_PMA_NPC_SRAM_EN appends the NPC SRAM region
//          (8000_0000-87ff_ffff, RWX) as entry 8 and sets PMA_NUM_DEFAULT to 9.
package ysyx_24080006_pma_pkg;

   typedef enum logic [1:0] {
      PMA_FETCH = 2'd0,
      PMA_LOAD  = 2'd1,
      PMA_STORE = 2'd2
   } pma_acc_e;

   typedef enum logic [2:0] {
      PMA_OK       = 3'd0,
      PMA_NOMAP    = 3'd1,
      PMA_PERM     = 3'd2,
      PMA_MISALIGN = 3'd3,
      PMA_WRAP     = 3'd4
   } pma_fault_e;

   typedef struct packed {
      logic [31:0] base;
      logic [31:0] last;
      logic        r;
      logic        w;
      logic        x;
      logic        periph;
   } pma_region_t;

   // Tables are stored in a fixed-size container; entries at or above the
   // configured region count are ignored by pma_lookup().
   localparam int PMA_MAX_REGIONS = 16;
   typedef pma_region_t [PMA_MAX_REGIONS-1:0] pma_table_t;

   typedef struct packed {
      logic       hit;
      logic [4:0] index;
   } pma_lookup_t;

`ifdef YSYX_24080006_PMA_NPC_SRAM_EN
   localparam int PMA_NUM_DEFAULT = 9;
`else
   localparam int PMA_NUM_DEFAULT = 8;
`endif

   function automatic pma_region_t pma_mk(input logic [31:0] base, input logic [31:0] last,
                                          input logic r, input logic w, input logic x,
                                          input logic periph);
      pma_region_t e;
      e.base   = base;
      e.last   = last;
      e.r      = r;
      e.w      = w;
      e.x      = x;
      e.periph = periph;
      return e;
   endfunction

   function automatic pma_table_t pma_default_fn();
      pma_table_t t;
      t    = '0;
      t[0] = pma_mk(32'h0200_0000, 32'h0200_ffff, 1'b1, 1'b0, 1'b0, 1'b1); // CLINT
      t[1] = pma_mk(32'h1000_0000, 32'h1000_0fff, 1'b1, 1'b1, 1'b0, 1'b1); // UART
      t[2] = pma_mk(32'h1000_2000, 32'h1000_200f, 1'b1, 1'b1, 1'b0, 1'b1); // GPIO
      t[3] = pma_mk(32'h1001_1000, 32'h1001_1007, 1'b1, 1'b0, 1'b0, 1'b1); // PS2
      t[4] = pma_mk(32'h2100_0000, 32'h211f_ffff, 1'b1, 1'b1, 1'b0, 1'b1); // VGA
      t[5] = pma_mk(32'h0f00_0000, 32'h0f00_1fff, 1'b1, 1'b1, 1'b1, 1'b0); // SRAM
      t[6] = pma_mk(32'h3000_0000, 32'h30ff_ffff, 1'b1, 1'b0, 1'b1, 1'b0); // FLASH
      t[7] = pma_mk(32'ha000_0000, 32'ha3ff_ffff, 1'b1, 1'b1, 1'b1, 1'b0); // SDRAM
`ifdef YSYX_24080006_PMA_NPC_SRAM_EN
      t[8] = pma_mk(32'h8000_0000, 32'h87ff_ffff, 1'b1, 1'b1, 1'b1, 1'b0); // NPC SRAM
`endif
      return t;
   endfunction

   localparam pma_table_t PMA_DEFAULT_TABLE = pma_default_fn();

   // Walks from the top entry down so the lowest matching index is the one kept.
   function automatic pma_lookup_t pma_lookup(input logic [31:0] addr, input logic [32:0] end_addr,
                                              input pma_table_t table_in, input int num);
      pma_lookup_t res;
      res = '0;
      for (int i = PMA_MAX_REGIONS - 1; i >= 0; i--) begin
         if (i < num && addr >= table_in[i].base && end_addr <= {1'b0, table_in[i].last}) begin
            res.hit   = 1'b1;
            res.index = 5'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ysyx_24080006_pma_match.sv
// rtl/ysyx_24080006_pma_match.sv - combinational region match, permission check and fault priority
//
// Ports: addr_i/type_i/size_i  request to classify
//        fault_o               pma_fault_e code (MISALIGN > WRAP > NOMAP > PERM > OK)
//        region_o              hit index, NUM_REGIONS on miss
//        periph_o              hit region is peripheral
module ysyx_24080006_pma_match
   import ysyx_24080006_pma_pkg::*;
#(
   parameter int         NUM_REGIONS = PMA_NUM_DEFAULT,
   parameter pma_table_t REGIONS     = PMA_DEFAULT_TABLE,
   parameter int         RW          = $clog2(NUM_REGIONS) + 1
) (
   input  logic [31:0]   addr_i,
   input  logic [1:0]    type_i,
   input  logic [1:0]    size_i,
   output logic [2:0]    fault_o,
   output logic [RW-1:0] region_o,
   output logic          periph_o
);

   logic [32:0] end_addr;
   logic        misalign;
   logic        allowed;
   pma_lookup_t lk;
   pma_region_t sel;

   always_comb begin
      // Size 3 is handled as a word.
      case (size_i)
         2'd0:    end_addr = {1'b0, addr_i};
         2'd1:    end_addr = {1'b0, addr_i} + 33'd1;
         default: end_addr = {1'b0, addr_i} + 33'd3;
      endcase
      misalign = (size_i == 2'd1 && addr_i[0]) || (size_i[1] && addr_i[1:0] != 2'b00);
      lk       = pma_lookup(addr_i, end_addr, REGIONS, NUM_REGIONS);
      sel      = REGIONS[lk.index[3:0]];
      case (type_i)
         PMA_FETCH: allowed = sel.x;
         PMA_LOAD:  allowed = sel.r;
         PMA_STORE: allowed = sel.w;
         default:   allowed = 1'b0;
      endcase

      if (misalign)          fault_o = PMA_MISALIGN;
      else if (end_addr[32]) fault_o = PMA_WRAP;
      else if (!lk.hit)      fault_o = PMA_NOMAP;
      else if (!allowed)     fault_o = PMA_PERM;
      else                   fault_o = PMA_OK;

      region_o = lk.hit ? RW'(lk.index) : RW'(NUM_REGIONS);
      periph_o = lk.hit && sel.periph;
   end

endmodule

// File: rtl/ysyx_24080006_pma_checker.sv
// rtl/ysyx_24080006_pma_checker.sv - registered PMA checker with sticky fault capture and fault counter
//
// Ports: clk_i, rst_ni (async, active-low)
//        req_valid_i/req_ready_o, req_addr_i, req_type_i, req_size_i    request
//        rsp_valid_o/rsp_ready_i, rsp_fault_o, rsp_region_o, rsp_periph_o response (1 cycle later)
//        fault_valid_o, fault_addr_o, fault_info_o {type, code}, fault_clr_i   sticky first-fault capture
//        fault_cnt_o                                                    saturating faulting-response count
// Config: YSYX_24080006_PMA_NPC_SRAM_EN (via the package) adds the NPC SRAM region.
module ysyx_24080006_pma_checker
   import ysyx_24080006_pma_pkg::*;
#(
   parameter int         NUM_REGIONS = PMA_NUM_DEFAULT,
   parameter pma_table_t REGIONS     = PMA_DEFAULT_TABLE,
   parameter int         CNT_W       = 16,
   localparam int        RW          = $clog2(NUM_REGIONS) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [31:0]      req_addr_i,
   input  logic [1:0]       req_type_i,
   input  logic [1:0]       req_size_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [2:0]       rsp_fault_o,
   output logic [RW-1:0]    rsp_region_o,
   output logic             rsp_periph_o,
   output logic             fault_valid_o,
   output logic [31:0]      fault_addr_o,
   output logic [4:0]       fault_info_o,
   input  logic             fault_clr_i,
   output logic [CNT_W-1:0] fault_cnt_o
);

   logic [2:0]       m_fault;
   logic [RW-1:0]    m_region;
   logic             m_periph;

   logic             rsp_valid_q,  rsp_valid_d;
   logic [2:0]       rsp_fault_q,  rsp_fault_d;
   logic [RW-1:0]    rsp_region_q, rsp_region_d;
   logic             rsp_periph_q, rsp_periph_d;
   logic [31:0]      rsp_addr_q,   rsp_addr_d;
   logic [1:0]       rsp_type_q,   rsp_type_d;
   logic             fault_valid_q, fault_valid_d;
   logic [31:0]      fault_addr_q,  fault_addr_d;
   logic [4:0]       fault_info_q,  fault_info_d;
   logic [CNT_W-1:0] fault_cnt_q,   fault_cnt_d;

   logic accept;
   logic rsp_hs;
   logic fault_hs;

   ysyx_24080006_pma_match #(
      .NUM_REGIONS (NUM_REGIONS),
      .REGIONS     (REGIONS),
      .RW          (RW)
   ) u_match (
      .addr_i   (req_addr_i),
      .type_i   (req_type_i),
      .size_i   (req_size_i),
      .fault_o  (m_fault),
      .region_o (m_region),
      .periph_o (m_periph)
   );

   assign req_ready_o = !rsp_valid_q || rsp_ready_i;
   assign accept      = req_valid_i && req_ready_o;
   assign rsp_hs      = rsp_valid_q && rsp_ready_i;
   assign fault_hs    = rsp_hs && (rsp_fault_q != PMA_OK);

   always_comb begin
      rsp_valid_d   = rsp_valid_q;
      rsp_fault_d   = rsp_fault_q;
      rsp_region_d  = rsp_region_q;
      rsp_periph_d  = rsp_periph_q;
      rsp_addr_d    = rsp_addr_q;
      rsp_type_d    = rsp_type_q;
      fault_valid_d = fault_valid_q;
      fault_addr_d  = fault_addr_q;
      fault_info_d  = fault_info_q;
      fault_cnt_d   = fault_cnt_q;

      if (accept) begin
         rsp_valid_d  = 1'b1;
         rsp_fault_d  = m_fault;
         rsp_region_d = m_region;
         rsp_periph_d = m_periph;
         rsp_addr_d   = req_addr_i;
         rsp_type_d   = req_type_i;
      end else if (rsp_hs) begin
         rsp_valid_d = 1'b0;
      end

      // A clear coinciding with a new fault lets the new fault load.
      if (fault_hs && (!fault_valid_q || fault_clr_i)) begin
         fault_valid_d = 1'b1;
         fault_addr_d  = rsp_addr_q;
         fault_info_d  = {rsp_type_q, rsp_fault_q};
      end else if (fault_clr_i) begin
         fault_valid_d = 1'b0;
      end

      if (fault_hs && fault_cnt_q != {CNT_W{1'b1}}) begin
         fault_cnt_d = fault_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q   <= 1'b0;
         rsp_fault_q   <= '0;
         rsp_region_q  <= RW'(NUM_REGIONS);
         rsp_periph_q  <= 1'b0;
         rsp_addr_q    <= '0;
         rsp_type_q    <= '0;
         fault_valid_q <= 1'b0;
         fault_addr_q  <= '0;
         fault_info_q  <= '0;
         fault_cnt_q   <= '0;
      end else begin
         rsp_valid_q   <= rsp_valid_d;
         rsp_fault_q   <= rsp_fault_d;
         rsp_region_q  <= rsp_region_d;
         rsp_periph_q  <= rsp_periph_d;
         rsp_addr_q    <= rsp_addr_d;
         rsp_type_q    <= rsp_type_d;
         fault_valid_q <= fault_valid_d;
         fault_addr_q  <= fault_addr_d;
         fault_info_q  <= fault_info_d;
         fault_cnt_q   <= fault_cnt_d;
      end
   end

   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_fault_o   = rsp_fault_q;
   assign rsp_region_o  = rsp_region_q;
   assign rsp_periph_o  = rsp_periph_q;
   assign fault_valid_o = fault_valid_q;
   assign fault_addr_o  = fault_addr_q;
   assign fault_info_o  = fault_info_q;
   assign fault_cnt_o   = fault_cnt_q;

endmodule

// File: tb/tb_ysyx_24080006_pma_checker.sv
// tb/tb_ysyx_24080006_pma_checker.sv - scoreboard bench for the PMA checker
module tb_ysyx_24080006_pma_checker;

`ifdef YSYX_24080006_PMA_NPC_SRAM_EN
   localparam int NR = 9;
   localparam logic [31:0] TB_BASE [NR] = '{32'h0200_0000, 32'h1000_0000, 32'h1000_2000, 32'h1001_1000,
                                            32'h2100_0000, 32'h0f00_0000, 32'h3000_0000, 32'ha000_0000,
                                            32'h8000_0000};
   localparam logic [31:0] TB_LAST [NR] = '{32'h0200_ffff, 32'h1000_0fff, 32'h1000_200f, 32'h1001_1007,
                                            32'h211f_ffff, 32'h0f00_1fff, 32'h30ff_ffff, 32'ha3ff_ffff,
                                            32'h87ff_ffff};
   // {r, w, x, periph}
   localparam logic [3:0]  TB_ATTR [NR] = '{4'b1001, 4'b1101, 4'b1101, 4'b1001, 4'b1101, 4'b1110,
                                            4'b1010, 4'b1110, 4'b1110};
`else
   localparam int NR = 8;
   localparam logic [31:0] TB_BASE [NR] = '{32'h0200_0000, 32'h1000_0000, 32'h1000_2000, 32'h1001_1000,
                                            32'h2100_0000, 32'h0f00_0000, 32'h3000_0000, 32'ha000_0000};
   localparam logic [31:0] TB_LAST [NR] = '{32'h0200_ffff, 32'h1000_0fff, 32'h1000_200f, 32'h1001_1007,
                                            32'h211f_ffff, 32'h0f00_1fff, 32'h30ff_ffff, 32'ha3ff_ffff};
   localparam logic [3:0]  TB_ATTR [NR] = '{4'b1001, 4'b1101, 4'b1101, 4'b1001, 4'b1101, 4'b1110,
                                            4'b1010, 4'b1110};
`endif
   localparam int RW = $clog2(NR) + 1;

   typedef struct {
      logic [2:0]  fault;
      int          region;
      logic        periph;
      logic [31:0] addr;
      logic [1:0]  typ;
      logic        dir;
      logic [2:0]  dfault;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [31:0]   req_addr_i = '0;
   logic [1:0]    req_type_i = '0;
   logic [1:0]    req_size_i = '0;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b1;
   logic [2:0]    rsp_fault_o;
   logic [RW-1:0] rsp_region_o;
   logic          rsp_periph_o;
   logic          fault_valid_o;
   logic [31:0]   fault_addr_o;
   logic [4:0]    fault_info_o;
   logic          fault_clr_i = 1'b0;
   logic [15:0]   fault_cnt_o;

   int   n_checks = 0;
   int   n_fail = 0;
   bit   rand_mode = 0;
   exp_t exp_q[$];

   // sticky/counter model
   logic        m_fv;
   logic [31:0] m_fa;
   logic [4:0]  m_fi;
   int          m_cnt;

   logic          hold_prev = 1'b0;
   logic [2:0]    h_fault;
   logic [RW-1:0] h_region;
   logic          h_periph;

   ysyx_24080006_pma_checker dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_addr_i    (req_addr_i),
      .req_type_i    (req_type_i),
      .req_size_i    (req_size_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_fault_o   (rsp_fault_o),
      .rsp_region_o  (rsp_region_o),
      .rsp_periph_o  (rsp_periph_o),
      .fault_valid_o (fault_valid_o),
      .fault_addr_o  (fault_addr_o),
      .fault_info_o  (fault_info_o),
      .fault_clr_i   (fault_clr_i),
      .fault_cnt_o   (fault_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint got, input longint want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [1:0] t, input logic [1:0] s);
      exp_t r;
      longint unsigned nb, e64;
      int hit;
      nb  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      e64 = {32'b0, a} + nb - 1;
      hit = -1;
      for (int i = NR - 1; i >= 0; i--)
         if ({32'b0, a} >= {32'b0, TB_BASE[i]} && e64 <= {32'b0, TB_LAST[i]}) hit = i;
      r.addr   = a;
      r.typ    = t;
      r.dir    = 1'b0;
      r.dfault = 3'd0;
      r.region = (hit < 0) ? NR : hit;
      r.periph = (hit < 0) ? 1'b0 : TB_ATTR[hit][0];
      if ({32'b0, a} % nb != 0)            r.fault = 3'd3;
      else if (e64 > 64'hffff_ffff)        r.fault = 3'd4;
      else if (hit < 0)                    r.fault = 3'd1;
      else if ((t == 2'd0 && !TB_ATTR[hit][1]) || (t == 2'd1 && !TB_ATTR[hit][3]) ||
               (t == 2'd2 && !TB_ATTR[hit][2]))
                                           r.fault = 3'd2;
      else                                 r.fault = 3'd0;
      return r;
   endfunction

   // Drives one request and waits for acceptance; the expectation is queued
   // just before the accepting edge.
   task automatic issue(input logic [31:0] a, input logic [1:0] t, input logic [1:0] s,
                        input logic dir, input logic [2:0] dfault);
      exp_t e;
      bit   done;
      e        = model(a, t, s);
      e.dir    = dir;
      e.dfault = dfault;
      req_valid_i = 1'b1;
      req_addr_i  = a;
      req_type_i  = t;
      req_size_i  = s;
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (req_ready_o) begin
            exp_q.push_back(e);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: request 0x%0h not accepted in 200 cycles", a);
      end
      req_valid_i = 1'b0;
   endtask

   // Monitor: checks sticky state against the model every cycle and pops the
   // scoreboard on each response handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         m_fv = 1'b0; m_fa = '0; m_fi = '0; m_cnt = 0;
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         chk("fault_valid", fault_valid_o, m_fv);
         chk("fault_addr", fault_addr_o, m_fa);
         chk("fault_info", fault_info_o, m_fi);
         chk("fault_cnt", fault_cnt_o, m_cnt);
         chk("req_ready", req_ready_o, !rsp_valid_o || rsp_ready_i);
         if (hold_prev) begin
            chk("hold_valid", rsp_valid_o, 1);
            chk("hold_fault", rsp_fault_o, h_fault);
            chk("hold_region", rsp_region_o, h_region);
            chk("hold_periph", rsp_periph_o, h_periph);
         end
         hold_prev = rsp_valid_o && !rsp_ready_i;
         h_fault = rsp_fault_o; h_region = rsp_region_o; h_periph = rsp_periph_o;
         if (rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_fault", rsp_fault_o, e.fault);
               chk("rsp_region", rsp_region_o, e.region);
               chk("rsp_periph", rsp_periph_o, e.periph);
               if (e.dir) chk("dir_fault", rsp_fault_o, e.dfault);
               if (e.fault != 3'd0 && (!m_fv || fault_clr_i)) begin
                  m_fv = 1'b1; m_fa = e.addr; m_fi = {e.typ, e.fault};
               end else if (fault_clr_i) begin
                  m_fv = 1'b0;
               end
               if (e.fault != 3'd0 && m_cnt < 65535) m_cnt++;
            end
         end else if (fault_clr_i) begin
            m_fv = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      if (rand_mode) begin
         #1;
         rsp_ready_i = ($urandom % 4) != 0;
         fault_clr_i = ($urandom % 8) == 0;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] a;
      int          ri;
      exp_t        eb;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp_valid", rsp_valid_o, 0);
      chk("reset_rsp_fault", rsp_fault_o, 0);
      chk("reset_rsp_region", rsp_region_o, NR);
      chk("reset_rsp_periph", rsp_periph_o, 0);
      chk("reset_fault_valid", fault_valid_o, 0);
      chk("reset_fault_addr", fault_addr_o, 0);
      chk("reset_fault_info", fault_info_o, 0);
      chk("reset_fault_cnt", fault_cnt_o, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed classification, back-to-back
      issue(32'h1000_0000, 2'd1, 2'd2, 1, 3'd0);
      chk("uart_region", rsp_region_o, 1);
      chk("uart_periph", rsp_periph_o, 1);
      issue(32'h3000_0010, 2'd2, 2'd2, 1, 3'd2);
      issue(32'h3000_0010, 2'd0, 2'd2, 1, 3'd0);
      chk("flash_periph", rsp_periph_o, 0);
      issue(32'h0f00_0001, 2'd1, 2'd1, 1, 3'd3);
      issue(32'hffff_fffc, 2'd1, 2'd2, 1, 3'd1);
      issue(32'h1000_0ffe, 2'd1, 2'd2, 1, 3'd3);
      issue(32'h1000_0fff, 2'd1, 2'd0, 1, 3'd0);
      issue(32'h0f00_2000, 2'd1, 2'd0, 1, 3'd1);
      issue(32'h0f00_1ffe, 2'd1, 2'd2, 1, 3'd3);
      issue(32'h1001_1004, 2'd1, 2'd3, 1, 3'd0);
      issue(32'h1001_1006, 2'd1, 2'd2, 1, 3'd3);
      issue(32'h0200_0000, 2'd2, 2'd2, 1, 3'd2);
`ifdef YSYX_24080006_PMA_NPC_SRAM_EN
      issue(32'h8000_0000, 2'd1, 2'd2, 1, 3'd0);
`else
      issue(32'h8000_0000, 2'd1, 2'd2, 1, 3'd1);
`endif
      repeat (2) @(posedge clk);
      #1;

      // back-pressure: second request waits while the first response stalls
      rsp_ready_i = 1'b0;
      issue(32'h1000_0000, 2'd1, 2'd2, 1, 3'd0);
      eb = model(32'h3000_0010, 2'd2, 2'd2);
      eb.dir = 1'b1; eb.dfault = 3'd2;
      req_valid_i = 1'b1; req_addr_i = 32'h3000_0010; req_type_i = 2'd2; req_size_i = 2'd2;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stall_req_ready", req_ready_o, 0);
         chk("stall_rsp_fault", rsp_fault_o, 0);
         chk("stall_rsp_region", rsp_region_o, 1);
      end
      @(posedge clk); #1;
      rsp_ready_i = 1'b1;
      @(negedge clk);
      chk("release_req_ready", req_ready_o, 1);
      exp_q.push_back(eb);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      chk("second_rsp_valid", rsp_valid_o, 1);
      chk("second_rsp_fault", rsp_fault_o, 2);
      @(posedge clk); #1;
      chk("drained_rsp_valid", rsp_valid_o, 0);

      // sticky capture: two faults, then a clear coincident with a third
      do_reset();
      @(posedge clk); #1;
      issue(32'h0f00_0001, 2'd1, 2'd1, 1, 3'd3);
      issue(32'hffff_fffc, 2'd2, 2'd2, 1, 3'd1);
      @(posedge clk); #1;
      chk("sticky_first_addr", fault_addr_o, 32'h0f00_0001);
      chk("sticky_first_info", fault_info_o, {2'd1, 3'd3});
      chk("sticky_cnt2", fault_cnt_o, 2);
      issue(32'h1000_0ffe, 2'd0, 2'd2, 1, 3'd3);
      fault_clr_i = 1'b1;
      @(posedge clk); #1;
      fault_clr_i = 1'b0;
      chk("sticky_third_valid", fault_valid_o, 1);
      chk("sticky_third_addr", fault_addr_o, 32'h1000_0ffe);
      chk("sticky_third_info", fault_info_o, {2'd0, 3'd3});
      chk("sticky_cnt3", fault_cnt_o, 3);
      fault_clr_i = 1'b1;
      @(posedge clk); #1;
      fault_clr_i = 1'b0;
      chk("clear_valid", fault_valid_o, 0);
      chk("clear_keeps_addr", fault_addr_o, 32'h1000_0ffe);
      chk("clear_keeps_cnt", fault_cnt_o, 3);

      // reset while a response is pending
      rsp_ready_i = 1'b0;
      issue(32'h0f00_0003, 2'd2, 2'd2, 1, 3'd3);
      rst_n = 1'b0;
      #1;
      chk("midreset_rsp_valid", rsp_valid_o, 0);
      chk("midreset_cnt", fault_cnt_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rsp_ready_i = 1'b1;
      @(posedge clk); #1;

      // randomized traffic
      rand_mode = 1;
      for (int n = 0; n < 400; n++) begin
         ri = $urandom % NR;
         case ($urandom % 4)
            0: a = $urandom;
            1: a = TB_BASE[ri] + ($urandom % 16);
            2: a = TB_LAST[ri] - ($urandom % 8);
            default: a = TB_BASE[ri] - ($urandom % 4);
         endcase
         issue(a, 2'($urandom % 3), 2'($urandom % 4), 0, 3'd0);
         if ($urandom % 4 == 0) begin
            @(posedge clk); #1;
         end
      end
      rand_mode = 0;
      @(posedge clk); #2;
      rsp_ready_i = 1'b1;
      fault_clr_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 0);
      chk("final_rsp_valid", rsp_valid_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_24080006_pma_checker.md
# ysyx_24080006_pma_checker

Registered physical-memory-attribute checker for the ysyx_24080006 core. It sits between the LSU/IFU address-generation stage and the bus master. Each request (fetch/load/store, byte/half/word) is classified against a parametrised region table, and the block returns, one cycle later, a hit region index, an uncacheable/peripheral flag, and a fault code. It also captures the first faulting access in a sticky register and keeps a saturating fault count for debug and difftest.

## Interface
Parameters:
- NUM_REGIONS, default PMA_NUM_DEFAULT (8, or 9 with NPC SRAM): number of table entries.
- REGIONS, default PMA_DEFAULT_TABLE: array of pma_region_t {base, last, r, w, x, periph}.
- CNT_W, default 16: fault counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&&ready.
- req_addr_i  in  32  byte address.
- req_type_i  in  2  pma_acc_e: FETCH=0, LOAD=1, STORE=2.
- req_size_i  in  2  0=byte, 1=half, 2=word; 3 is treated as word.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_fault_o  out  3  pma_fault_e code, see Operation.
- rsp_region_o  out  $clog2(NUM_REGIONS)+1  hit index; NUM_REGIONS on miss.
- rsp_periph_o  out  1  hit region is peripheral (uncacheable, no burst).
- fault_valid_o  out  1  sticky fault captured.
- fault_addr_o  out  32  captured address.
- fault_info_o  out  5  {type[1:0], code[2:0]} of the captured fault.
- fault_clr_i  in  1  clears the sticky capture.
- fault_cnt_o  out  CNT_W  saturating count of faulting responses.

## Operation
- Last byte address: end = addr + (1<<size) - 1, computed at 33 bits. If bit 32 is set, the access wraps past 0xffff_ffff.
- Region hit condition: base <= addr && end <= last. When several entries match, the lowest index wins.
- Fault codes (pma_fault_e), checked in priority order:
  - MISALIGN=3: half with addr[0] set, or word with addr[1:0] != 0.
  - WRAP=4: the wrap condition above.
  - NOMAP=1: no region hit, including accesses that straddle two regions.
  - PERM=2: the hit region lacks r (LOAD), w (STORE) or x (FETCH).
  - OK=0: none of the above.
- Default table (inclusive ranges):
  - CLINT 0200_0000–0200_ffff: R, periph.
  - UART 1000_0000–1000_0fff: RW, periph.
  - GPIO 1000_2000–1000_200f: RW, periph.
  - PS2 1001_1000–1001_1007: R, periph.
  - VGA 2100_0000–211f_ffff: RW, periph.
  - SRAM 0f00_0000–0f00_1fff: RWX.
  - FLASH 3000_0000–30ff_ffff: RX.
  - SDRAM a000_0000–a3ff_ffff: RWX.
- Sticky capture, on each response handshake with fault != OK:
  - If fault_valid_o is 0, or fault_clr_i is asserted in the same cycle, load addr/type/code and set fault_valid_o.
  - When clear and a new fault coincide, the new fault wins: fault_valid_o stays 1 with the new data.
  - fault_clr_i alone clears fault_valid_o only; fault_addr_o and fault_info_o keep their last values.
- fault_cnt_o increments by one per faulting response handshake and saturates at all-ones. It is not cleared by fault_clr_i.

## Timing
- One pipeline stage. Accepted request to rsp_valid_o: 1 cycle.
- req_ready_o = !rsp_valid_o || rsp_ready_i. Combinational, so back-to-back requests run at full throughput.
- Response fields hold stable while rsp_valid_o && !rsp_ready_i.
- rsp_valid_o falls after a handshake unless a new request is accepted in the same cycle.
- Reset values: rsp_valid_o=0, rsp_fault_o=0, rsp_region_o=NUM_REGIONS, rsp_periph_o=0, fault_valid_o=0, fault_addr_o=0, fault_info_o=0, fault_cnt_o=0.
- Reset asserted mid-operation drops any pending response with no handshake.

## Configuration
- YSYX_24080006_PMA_NPC_SRAM_EN defined: appends region 8000_0000–87ff_ffff (RWX, not periph) as the last table entry; PMA_NUM_DEFAULT=9.
- Undefined: table has 8 entries; accesses to 0x8000_0000 return NOMAP.

## Structure
- Shared package ysyx_24080006_pma_pkg holds:
  - pma_region_t, pma_acc_e, pma_fault_e.
  - PMA_NUM_DEFAULT and PMA_DEFAULT_TABLE, with the macro-controlled entry.
  - Function pma_lookup(addr, end, table) returning {hit, index}.
- One sub-module, ysyx_24080006_pma_match: combinational per-entry range/permission compare plus lowest-index priority encoder.
- The top level holds the response register, sticky capture and counter.

## Test plan
- LOAD word at 0x1000_0000 -> after 1 cycle: fault OK, region 1, periph 1.
- STORE word at 0x3000_0010 -> PERM. FETCH at 0x3000_0010 -> OK, periph 0.
- LOAD half at 0x0f00_0001 -> MISALIGN. LOAD word at 0xffff_fffc -> NOMAP.
- LOAD word at 0x1000_0ffe (size 1 at 0x1000_0fff with byte size passes) -> MISALIGN. LOAD half at 0x0f00_1fff+... i.e. byte at 0x0f00_2000 -> NOMAP.
- Hold rsp_ready_i=0 for 3 cycles with a second request pending -> req_ready_o=0 and response stable; then both responses delivered in order on consecutive cycles.
- Fault, then a second fault, then clear coincident with a third fault -> capture keeps the first fault's address until the clear, then shows the third; fault_cnt_o=3. With the macro, LOAD at 0x8000_0000 -> OK; without it -> NOMAP.
